reg_scoreboard: RTL and testbench

- Tracks destination registers of in-flight long-latency instructions (loads, multi-cycle mul/div). Sits at the ID stage.
- Asserts a stall when the instruction being issued reads or overwrites a register whose result is not yet available.
- Counterpart to the EX-stage forwarding unit: forwarding consumes results already in MEM/WB; this block withholds issue until the producer reaches writeback.
- Bounds the number of outstanding long operations.

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_hit_check.sv | 39 +++
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
//   Shared constants and types for the ID-stage register scoreboard.
//   - REG_ADDR_W : width of an architectural register index
//   - NREGS_ARCH : architectural register count
//   - X0         : hard-wired zero register, never tracked
//   - stall_cause_e : stall-cause encoding for debug and performance counters
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREGS_ARCH = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    SB_NONE = 2'd0,
    SB_RAW  = 2'd1,
    SB_WAW  = 2'd2,
    SB_CAP  = 2'd3
  } stall_cause_e;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_hit_check.sv
// -----------------------------------------------------------------------------
// sb_hit_check
//   Combinational dependency check of the ID instruction against the
//   effective pending mask (pending bits with same-cycle writebacks removed).
//   Ports:
//     eff_pending          : per-register pending bit, writebacks already removed
//     rs1, rs2, rd         : register indices of the ID instruction
//     uses_rs1, uses_rs2   : instruction reads the corresponding source
//     writes_rd            : instruction writes rd
//     raw_hit              : a read source is still pending
//     waw_hit              : the destination is still pending
// -----------------------------------------------------------------------------
module sb_hit_check
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_ARCH
) (
  input  logic [NREGS-1:0]      eff_pending,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic                  writes_rd,
  output logic                  raw_hit,
  output logic                  waw_hit
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never tracked, so it can never cause a hit even if a bit were set.
  assign rs1_hit = uses_rs1 && (rs1 != X0) && eff_pending[rs1];
  assign rs2_hit = uses_rs2 && (rs2 != X0) && eff_pending[rs2];

  assign raw_hit = rs1_hit || rs2_hit;
  assign waw_hit = writes_rd && (rd != X0) && eff_pending[rd];

endmodule : sb_hit_check

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   ID-stage scoreboard for long-latency producers (loads, mul/div). Holds a
//   pending bit per destination register and stalls issue on RAW/WAW hazards
//   against those registers, or when the outstanding-operation budget is used.
//   Ports:
//     clk, reset          : clock and synchronous active-high reset
//     issue_*             : ID instruction description and request
//     flush               : squash the ID instruction this cycle
//     wb_valid, wb_rd     : long-latency writeback this cycle
//     stall               : combinational hold for IF/ID
//     issue_fire          : the ID instruction issues this cycle
//     pending_mask        : registered pending bit per register
//     outstanding         : registered number of pending long writes
//     full                : outstanding budget exhausted
//     wb_err              : sticky, writeback to a non-pending register seen
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS           = NREGS_ARCH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  input  logic                  issue_writes_rd,
  input  logic                  issue_is_long,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic                  issue_fire,
  output logic [NREGS-1:0]      pending_mask,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  full,
  output logic                  wb_err
);

  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] eff_pending;
  logic             wb_live;     // writeback to a non-zero register
  logic             wb_clears;   // writeback retires a pending register
  logic             set_fire;    // an issuing long write claims a register
  logic             raw_hit;
  logic             waw_hit;
  logic             cap_hit;

  assign wb_live   = wb_valid && (wb_rd != X0);
  assign wb_clears = wb_live && pending_mask[wb_rd];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    clr_vec = '0;
    if (wb_live) clr_vec[wb_rd] = 1'b1;
  end

  // A same-cycle writeback satisfies the dependency; the WB forwarding path
  // supplies the data.
  assign eff_pending = pending_mask & ~clr_vec;

  sb_hit_check #(
    .NREGS (NREGS)
  ) u_hit_check (
    .eff_pending (eff_pending),
    .rs1         (issue_rs1),
    .rs2         (issue_rs2),
    .rd          (issue_rd),
    .uses_rs1    (issue_uses_rs1),
    .uses_rs2    (issue_uses_rs2),
    .writes_rd   (issue_writes_rd),
    .raw_hit     (raw_hit),
    .waw_hit     (waw_hit)
  );

  assign full = (outstanding == CNT_W'(MAX_OUTSTANDING));

  // A retiring writeback in the same cycle frees a slot for the new long op.
  assign cap_hit = issue_is_long && issue_writes_rd && (issue_rd != X0) &&
                   full && !wb_clears;

  assign stall      = issue_valid && (raw_hit || waw_hit || cap_hit);
  assign issue_fire = issue_valid && !stall && !flush;

  // Only long-latency writers are tracked; short ones are covered by the
  // EX-stage forwarding unit.
  assign set_fire = issue_fire && issue_is_long && issue_writes_rd &&
                    (issue_rd != X0);

  always_comb begin
    set_vec = '0;
    if (set_fire) set_vec[issue_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mask <= '0;
      outstanding  <= '0;
      wb_err       <= 1'b0;
    end else begin
      // Set is applied after clear so a register re-claimed in its own
      // writeback cycle stays pending.
      pending_mask <= eff_pending | set_vec;

      // Overflow is prevented by cap_hit; underflow by requiring a real
      // pending bit before counting a clear.
      unique case ({set_fire, wb_clears})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (wb_live && !pending_mask[wb_rd]) wb_err <= 1'b1;
    end
  end

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed test of reg_scoreboard. Inputs change on the falling edge; the
//   combinational outputs are checked 1 ns later and registered outputs on the
//   following falling edge.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_uses_rs1;
  logic        issue_uses_rs2;
  logic        issue_writes_rd;
  logic        issue_is_long;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending_mask;
  logic [2:0]  outstanding;
  logic        full;
  logic        wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(
    .NREGS           (32),
    .MAX_OUTSTANDING (4),
    .CNT_W           (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_rd        (issue_rd),
    .issue_uses_rs1  (issue_uses_rs1),
    .issue_uses_rs2  (issue_uses_rs2),
    .issue_writes_rd (issue_writes_rd),
    .issue_is_long   (issue_is_long),
    .flush           (flush),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .issue_fire      (issue_fire),
    .pending_mask    (pending_mask),
    .outstanding     (outstanding),
    .full            (full),
    .wb_err          (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_rs1       = '0;
    issue_rs2       = '0;
    issue_rd        = '0;
    issue_uses_rs1  = 1'b0;
    issue_uses_rs2  = 1'b0;
    issue_writes_rd = 1'b0;
    issue_is_long   = 1'b0;
    flush           = 1'b0;
    wb_valid        = 1'b0;
    wb_rd           = '0;
  endtask

  task automatic issue(input logic is_long, input logic writes, input logic [4:0] rd,
                       input logic u1, input logic [4:0] rs1,
                       input logic u2, input logic [4:0] rs2);
    issue_valid     = 1'b1;
    issue_is_long   = is_long;
    issue_writes_rd = writes;
    issue_rd        = rd;
    issue_uses_rs1  = u1;
    issue_rs1       = rs1;
    issue_uses_rs2  = u2;
    issue_rs2       = rs2;
  endtask

  task automatic no_issue();
    issue_valid     = 1'b0;
    issue_is_long   = 1'b0;
    issue_writes_rd = 1'b0;
    issue_uses_rs1  = 1'b0;
    issue_uses_rs2  = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid = v;
    wb_rd    = rd;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    settle();
    check("rst_pending", pending_mask, 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_full", 32'(full), 32'd0);

    // RAW: long write x5, then a reader of x5 stalls until its writeback
    issue(1, 1, 5'd5, 0, 5'd0, 0, 5'd0);
    settle();
    check("raw_prod_fire", 32'(issue_fire), 32'd1);
    step();
    check("raw_pending5", pending_mask, 32'h0000_0020);
    check("raw_outst1", 32'(outstanding), 32'd1);
    issue(0, 1, 5'd10, 1, 5'd5, 0, 5'd0);
    settle();
    check("raw_stall_c1", 32'(stall), 32'd1);
    check("raw_nofire_c1", 32'(issue_fire), 32'd0);
    step();
    settle();
    check("raw_stall_c2", 32'(stall), 32'd1);
    wb(1, 5'd5);
    settle();
    check("raw_wb_stall", 32'(stall), 32'd0);
    check("raw_wb_fire", 32'(issue_fire), 32'd1);
    step();
    idle();
    check("raw_pending_clr", pending_mask, 32'h0);
    check("raw_outst0", 32'(outstanding), 32'd0);

    // WAW: long x7, then a short writer of x7
    issue(1, 1, 5'd7, 0, 5'd0, 0, 5'd0);
    step();
    check("waw_outst1", 32'(outstanding), 32'd1);
    issue(0, 1, 5'd7, 0, 5'd0, 0, 5'd0);
    settle();
    check("waw_stall_c1", 32'(stall), 32'd1);
    step();
    settle();
    check("waw_stall_c2", 32'(stall), 32'd1);
    wb(1, 5'd7);
    settle();
    check("waw_wb_stall", 32'(stall), 32'd0);
    step();
    idle();
    check("waw_outst0", 32'(outstanding), 32'd0);
    check("waw_pending0", pending_mask, 32'h0);

    // Capacity: fill x1..x4
    for (int r = 1; r <= 4; r++) begin
      issue(1, 1, 5'(r), 0, 5'd0, 0, 5'd0);
      step();
    end
    check("cap_outst4", 32'(outstanding), 32'd4);
    check("cap_full", 32'(full), 32'd1);
    check("cap_pending", pending_mask, 32'h0000_001E);
    issue(1, 1, 5'd9, 0, 5'd0, 0, 5'd0);
    settle();
    check("cap_stall", 32'(stall), 32'd1);
    step();
    check("cap_no_set", pending_mask, 32'h0000_001E);
    wb(1, 5'd2);
    settle();
    check("cap_wb_stall", 32'(stall), 32'd0);
    check("cap_wb_fire", 32'(issue_fire), 32'd1);
    step();
    idle();
    check("cap_outst_keep", 32'(outstanding), 32'd4);
    check("cap_pending_swap", pending_mask, 32'h0000_021A);
    // drain x1, x3, x4, x9
    wb(1, 5'd1); step();
    wb(1, 5'd3); step();
    wb(1, 5'd4); step();
    wb(1, 5'd9); step();
    idle();
    check("drain_outst0", 32'(outstanding), 32'd0);
    check("drain_pending0", pending_mask, 32'h0);
    check("drain_no_err", 32'(wb_err), 32'd0);

    // Same-cycle writeback and re-claim of x6
    issue(1, 1, 5'd6, 0, 5'd0, 0, 5'd0);
    step();
    wb(1, 5'd6);
    settle();
    check("reclaim_fire", 32'(issue_fire), 32'd1);
    step();
    idle();
    check("reclaim_pending", pending_mask, 32'h0000_0040);
    check("reclaim_outst", 32'(outstanding), 32'd1);
    wb(1, 5'd6);
    step();
    idle();
    check("reclaim_drain", 32'(outstanding), 32'd0);

    // Writeback to non-pending x12 sets the sticky error
    wb(1, 5'd12);
    step();
    idle();
    check("err_set", 32'(wb_err), 32'd1);
    check("err_state_kept", pending_mask, 32'h0);
    step();
    check("err_sticky", 32'(wb_err), 32'd1);

    // Build three outstanding ops: x5, x6, x11
    issue(1, 1, 5'd5, 0, 5'd0, 0, 5'd0); step();
    issue(1, 1, 5'd6, 0, 5'd0, 0, 5'd0); step();
    issue(1, 1, 5'd11, 0, 5'd0, 0, 5'd0); step();
    idle();
    check("three_pending", pending_mask, 32'h0000_0860);
    check("three_outst", 32'(outstanding), 32'd3);

    // x0 sources never stall
    issue(0, 1, 5'd20, 1, 5'd0, 1, 5'd0);
    settle();
    check("x0_no_stall", 32'(stall), 32'd0);
    step();
    idle();

    // Flush on a non-stalling long issue
    issue(1, 1, 5'd8, 0, 5'd0, 0, 5'd0);
    flush = 1'b1;
    settle();
    check("flush_nofire", 32'(issue_fire), 32'd0);
    step();
    check("flush_no_set", pending_mask, 32'h0000_0860);
    check("flush_outst", 32'(outstanding), 32'd3);
    // Flush on a stalling (WAW) long issue
    issue(1, 1, 5'd5, 0, 5'd0, 0, 5'd0);
    flush = 1'b1;
    settle();
    check("flush_stall", 32'(stall), 32'd1);
    check("flush_stall_nofire", 32'(issue_fire), 32'd0);
    step();
    idle();
    check("flush_stall_pending", pending_mask, 32'h0000_0860);

    // Reset with three outstanding
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_pending", pending_mask, 32'h0);
    check("mid_rst_outst", 32'(outstanding), 32'd0);
    check("mid_rst_wb_err", 32'(wb_err), 32'd0);

    // Writeback to x0 is ignored
    wb(1, 5'd0);
    step();
    idle();
    check("wb_x0_no_err", 32'(wb_err), 32'd0);
    check("wb_x0_outst", 32'(outstanding), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_scoreboard
